// File: rtl/ppc_pkg.sv
// ppc_pkg: shared constants and types for the ping-pong sequencer.
`default_nettype none

package ppc_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int LEG_W_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_LOAD = 2'd1,
        CMD_STEP = 2'd2,
        CMD_FLIP = 2'd3
    } core_cmd_t;

endpackage

`default_nettype wire

// File: rtl/ppc_core.sv
// ppc_core: up/down count datapath owning the count value and direction.
`default_nettype none

module ppc_core
    import ppc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  core_cmd_t        cmd,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] out,
    output logic             direction,
    output logic             at_endpoint
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            direction <= DIR_UP;
        end else begin
            case (cmd)
                CMD_LOAD: begin
                    out       <= load_val;
                    direction <= DIR_UP;
                end
                CMD_STEP: out <= direction ? out + 1'b1 : out - 1'b1;
                // Turnaround: reverse and move one step back inside the range
                CMD_FLIP: begin
                    direction <= ~direction;
                    out       <= direction ? out - 1'b1 : out + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign at_endpoint = direction ? (out == hi) : (out == lo);

endmodule

`default_nettype wire

// File: rtl/ping_pong_sequencer.sv
// ping_pong_sequencer: run control FSM, leg counter and configuration check
// around the ppc_core up/down datapath.
`default_nettype none

module ping_pong_sequencer
    import ppc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEG_W = LEG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [LEG_W-1:0] legs,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             direction,
    output logic [WIDTH-1:0] out,
    output logic [LEG_W-1:0] leg
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [LEG_W-1:0] r_legs;
    core_cmd_t        w_cmd;
    logic             w_at_end;
    logic             w_cfg_ok;
    logic             w_last_leg;

    assign w_cfg_ok   = (lo < hi) && (legs != '0);
    assign w_last_leg = (leg == r_legs);

    always_comb begin
        w_cmd = CMD_HOLD;
        case (r_state)
            ST_IDLE: if (start && w_cfg_ok) w_cmd = CMD_LOAD;
            ST_RUN: begin
                if (!abort && !pause) begin
                    if (!w_at_end)        w_cmd = CMD_STEP;
                    else if (!w_last_leg) w_cmd = CMD_FLIP;
                end
            end
            default: ;
        endcase
    end

    ppc_core #(.WIDTH(WIDTH)) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (w_cmd),
        .load_val    (lo),
        .lo          (r_lo),
        .hi          (r_hi),
        .out         (out),
        .direction   (direction),
        .at_endpoint (w_at_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_lo    <= '0;
            r_hi    <= '0;
            r_legs  <= '0;
            leg     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_lo    <= lo;
                            r_hi    <= hi;
                            r_legs  <= legs;
                            leg     <= {{(LEG_W-1){1'b0}}, 1'b1};
                            busy    <= 1'b1;
                            r_state <= ST_RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (pause) begin
                        r_state <= ST_HOLD;
                    end else if (w_at_end) begin
                        if (w_last_leg) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            leg <= leg + 1'b1;
                        end
                    end
                end
                // Resume costs one edge with no step
                ST_HOLD: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (!pause) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
